primitive_assembler: RTL and testbench
======================================

Name: primitive_assembler

Overview:
- Sits directly downstream of the instruction-decode stage; consumes its StartPrimitive/PrimitiveType/EndPrimitive/Draw/NewVertex/Vertex outputs.
- Groups incoming vertices into points, lines and triangles according to the active primitive type.
- Presents each completed primitive, or a Draw token, to the rasterizer through a valid/ready output register.
- Drives Stall back to decode whenever that output register cannot accept a new result.

Parameters:
- VERTEX_WIDTH, 32, vertex word width; X = [15:0], Y = [31:16].
- COUNT_WIDTH, 16, width of the emitted-primitive counter.

Ports:
- CLK  in  1  clock.
- RESET  in  1  reset, asynchronous, active-high.
- StartPrimitive  in  1  begin primitive; type on PrimitiveType.
- PrimitiveType  in  4  0 points, 1 lines, 2 line strip, 3 triangles, 4 triangle strip, 5 triangle fan.
- EndPrimitive  in  1  end current primitive.
- Draw  in  1  frame-flush command.
- NewVertex  in  1  Vertex is valid this cycle.
- Vertex  in  VERTEX_WIDTH  vertex data.
- Stall  out  1  to decode; combinational, equals out_valid & ~out_ready.
- out_ready  in  1  rasterizer accepts the output register this cycle.
- out_valid  out  1  output register holds a result.
- out_cmd  out  2  00 primitive, 01 draw token.
- out_type  out  4  primitive type of the emitted item: 0 point, 1 line, 3 triangle.
- out_v0, out_v1, out_v2  out  VERTEX_WIDTH each  primitive vertices; unused fields are 0.
- prim_count  out  COUNT_WIDTH  number of primitives accepted by the rasterizer; wraps.
- err  out  1  sticky protocol error.

Behaviour:
- Reset: every output 0 (Stall 0), state IDLE, vertex count 0, parity 0, slots A/B 0. Reset mid-operation drops any partial primitive and the output register contents.
- Input consumption:
  - Inputs are consumed only at a posedge where Stall = 0.
  - While Stall = 1, decode holds its outputs, so the same inputs must be presented again. Consuming them twice is forbidden.
- Priority when several flags are high in one consumed cycle: StartPrimitive > EndPrimitive > Draw > NewVertex. Lower-priority flags are dropped and err is set.
- State IDLE:
  - StartPrimitive with type 0..5 -> ASSEMBLE; latch type; count = 0; parity = 0.
  - Type 6..15 -> stay IDLE; set err.
  - NewVertex -> drop the vertex; set err.
  - EndPrimitive -> ignored.
- State ASSEMBLE:
  - StartPrimitive -> restart with the new type; discard partial vertices.
  - EndPrimitive -> IDLE; discard partial vertices, no emit.
- Vertex handling in ASSEMBLE, per latched type (V = incoming vertex; A, B are internal slots):
  - Points: emit (V).
  - Lines: count 0 -> A = V, count = 1. Count 1 -> emit (A, V), count = 0.
  - Line strip: count 0 -> A = V, count = 1. Otherwise -> emit (A, V), then A = V.
  - Triangles: count 0 -> A; count 1 -> B; count 2 -> emit (A, B, V), count = 0.
  - Triangle strip:
    - After A and B are filled, each vertex emits (A, B, V) when parity = 0, or (B, A, V) when parity = 1.
    - Then A = B, B = V, parity toggles.
  - Triangle fan: after A and B are filled, each vertex emits (A, B, V), then B = V. A stays fixed.
- Draw, in any state: emit a token with out_cmd = 01, out_type = 0, all vertex fields 0. Assembly state is unchanged.
- Output register:
  - Loaded at the posedge that consumes the emitting input. out_valid rises the following cycle (1-cycle latency).
  - Holds its value until a cycle with out_valid & out_ready.
  - If out_ready is high while a new emit is consumed in the same cycle, the register reloads back-to-back (full throughput, no bubble).
  - If out_ready is high with no new emit, out_valid falls next cycle.
- Non-emitting inputs (vertex storage, Start, End) are consumed even while out_valid = 1, provided Stall = 0.
- prim_count: increments on each out_valid & out_ready with out_cmd = 00. Draw tokens are not counted. Wraps from 2^COUNT_WIDTH - 1 to 0.
- err: cleared only by RESET.

Test Plan:
- Triangles with out_ready = 1: Start type 3, then vertices 0x00010002, 0x00030004, 0x00050006 -> one triangle, out_type 3, v0..v2 in that order; prim_count = 1.
- Triangle strip with 5 vertices V0..V4 -> (V0,V1,V2), (V2,V1,V3), (V2,V3,V4); three emits on consecutive cycles.
- Back-pressure: line strip, out_ready = 0 after the first emit.
  - Stall goes high; the held vertex is not consumed twice.
  - When out_ready = 1 for one cycle, the next line is emitted exactly once; prim_count increments by 1 per acceptance.
- Partial discard: triangles, two vertices, then EndPrimitive, then Draw -> no triangle; one token with out_cmd = 01 and zero vertex fields.
- Error paths:
  - NewVertex in IDLE -> err = 1, no output.
  - Start with type 9 -> err stays 1, state IDLE.
  - RESET asserted mid-fan -> all outputs 0 immediately, asynchronously.
- Counter wrap: COUNT_WIDTH = 4, points mode, 17 accepted points -> prim_count = 1.

Source files
------------

// File: rtl/primitive_assembler.sv
// Groups decoded vertices into points, lines and triangles and hands each
// result (or a Draw token) to the rasterizer through a valid/ready register.
module primitive_assembler #(
    parameter int VERTEX_WIDTH = 32,
    parameter int COUNT_WIDTH  = 16
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    StartPrimitive,
    input  logic [3:0]              PrimitiveType,
    input  logic                    EndPrimitive,
    input  logic                    Draw,
    input  logic                    NewVertex,
    input  logic [VERTEX_WIDTH-1:0] Vertex,
    output logic                    Stall,
    input  logic                    out_ready,
    output logic                    out_valid,
    output logic [1:0]              out_cmd,
    output logic [3:0]              out_type,
    output logic [VERTEX_WIDTH-1:0] out_v0,
    output logic [VERTEX_WIDTH-1:0] out_v1,
    output logic [VERTEX_WIDTH-1:0] out_v2,
    output logic [COUNT_WIDTH-1:0]  prim_count,
    output logic                    err
);
    typedef enum logic {IDLE, ASSEMBLE} state_t;

    localparam logic [3:0] P_POINT  = 4'd0;
    localparam logic [3:0] P_LINES  = 4'd1;
    localparam logic [3:0] P_LSTRIP = 4'd2;
    localparam logic [3:0] P_TRI    = 4'd3;
    localparam logic [3:0] P_TSTRIP = 4'd4;
    localparam logic [3:0] P_TFAN   = 4'd5;

    state_t                  state, state_nx;
    logic [3:0]              ptype, ptype_nx;
    logic [1:0]              cnt, cnt_nx;
    logic                    parity, parity_nx;
    logic [VERTEX_WIDTH-1:0] slot_a, slot_a_nx, slot_b, slot_b_nx;

    logic                    consume, emit, err_set;
    logic [1:0]              e_cmd;
    logic [3:0]              e_type;
    logic [VERTEX_WIDTH-1:0] e_v0, e_v1, e_v2;
    logic [2:0]              nflags;

    assign Stall   = out_valid & ~out_ready;
    assign consume = ~Stall;
    assign nflags  = 3'(StartPrimitive) + 3'(EndPrimitive)
                   + 3'(Draw) + 3'(NewVertex);

    always_comb begin
        state_nx  = state;
        ptype_nx  = ptype;
        cnt_nx    = cnt;
        parity_nx = parity;
        slot_a_nx = slot_a;
        slot_b_nx = slot_b;
        emit      = 1'b0;
        err_set   = (nflags > 3'd1);
        e_cmd     = 2'b00;
        e_type    = 4'd0;
        e_v0      = '0;
        e_v1      = '0;
        e_v2      = '0;
        if (StartPrimitive) begin
            cnt_nx    = 2'd0;
            parity_nx = 1'b0;
            if (PrimitiveType <= P_TFAN) begin
                state_nx = ASSEMBLE;
                ptype_nx = PrimitiveType;
            end else begin
                state_nx = IDLE;
                err_set  = 1'b1;
            end
        end else if (EndPrimitive) begin
            state_nx = IDLE;
            cnt_nx   = 2'd0;
        end else if (Draw) begin
            emit  = 1'b1;
            e_cmd = 2'b01;
        end else if (NewVertex) begin
            if (state == IDLE) begin
                err_set = 1'b1;
            end else begin
                // Fill slots A/B first; later vertices close a primitive
                unique case (ptype)
                    P_POINT: begin
                        emit = 1'b1;
                        e_v0 = Vertex;
                    end
                    P_LINES, P_LSTRIP: begin
                        if (cnt == 2'd0) begin
                            slot_a_nx = Vertex;
                            cnt_nx    = 2'd1;
                        end else begin
                            emit   = 1'b1;
                            e_type = P_LINES;
                            e_v0   = slot_a;
                            e_v1   = Vertex;
                            if (ptype == P_LINES) cnt_nx = 2'd0;
                            else slot_a_nx = Vertex;
                        end
                    end
                    P_TRI, P_TSTRIP, P_TFAN: begin
                        if (cnt == 2'd0) begin
                            slot_a_nx = Vertex;
                            cnt_nx    = 2'd1;
                        end else if (cnt == 2'd1) begin
                            slot_b_nx = Vertex;
                            cnt_nx    = 2'd2;
                        end else begin
                            emit   = 1'b1;
                            e_type = P_TRI;
                            e_v0   = slot_a;
                            e_v1   = slot_b;
                            e_v2   = Vertex;
                            if (ptype == P_TRI) begin
                                cnt_nx = 2'd0;
                            end else if (ptype == P_TFAN) begin
                                slot_b_nx = Vertex;
                            end else begin
                                if (parity) begin
                                    e_v0 = slot_b;
                                    e_v1 = slot_a;
                                end
                                slot_a_nx = slot_b;
                                slot_b_nx = Vertex;
                                parity_nx = ~parity;
                            end
                        end
                    end
                    default: err_set = 1'b1;
                endcase
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state  <= IDLE;
            ptype  <= '0;
            cnt    <= '0;
            parity <= 1'b0;
            slot_a <= '0;
            slot_b <= '0;
            err    <= 1'b0;
        end else if (consume) begin
            state  <= state_nx;
            ptype  <= ptype_nx;
            cnt    <= cnt_nx;
            parity <= parity_nx;
            slot_a <= slot_a_nx;
            slot_b <= slot_b_nx;
            err    <= err | err_set;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            out_valid  <= 1'b0;
            out_cmd    <= '0;
            out_type   <= '0;
            out_v0     <= '0;
            out_v1     <= '0;
            out_v2     <= '0;
            prim_count <= '0;
        end else begin
            if (out_valid && out_ready && out_cmd == 2'b00)
                prim_count <= prim_count + 1'b1;
            if (consume && emit) begin
                out_valid <= 1'b1;
                out_cmd   <= e_cmd;
                out_type  <= e_type;
                out_v0    <= e_v0;
                out_v1    <= e_v1;
                out_v2    <= e_v2;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_primitive_assembler.sv
// Directed bench for primitive_assembler with hand-computed expectations.
module tb_primitive_assembler;
    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        StartPrimitive = 1'b0;
    logic [3:0]  PrimitiveType = '0;
    logic        EndPrimitive = 1'b0;
    logic        Draw = 1'b0;
    logic        NewVertex = 1'b0;
    logic [31:0] Vertex = '0;
    logic        Stall;
    logic        out_ready = 1'b1;
    logic        out_valid;
    logic [1:0]  out_cmd;
    logic [3:0]  out_type;
    logic [31:0] out_v0, out_v1, out_v2;
    logic [3:0]  prim_count;
    logic        err;

    int errors = 0;
    int checks = 0;

    primitive_assembler #(.VERTEX_WIDTH(32), .COUNT_WIDTH(4)) dut (
        .CLK(CLK), .RESET(RESET),
        .StartPrimitive(StartPrimitive), .PrimitiveType(PrimitiveType),
        .EndPrimitive(EndPrimitive), .Draw(Draw),
        .NewVertex(NewVertex), .Vertex(Vertex),
        .Stall(Stall), .out_ready(out_ready), .out_valid(out_valid),
        .out_cmd(out_cmd), .out_type(out_type),
        .out_v0(out_v0), .out_v1(out_v1), .out_v2(out_v2),
        .prim_count(prim_count), .err(err)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc(input logic s, input logic [3:0] t, input logic e,
                       input logic d, input logic nv, input logic [31:0] v);
        StartPrimitive = s;
        PrimitiveType  = t;
        EndPrimitive   = e;
        Draw           = d;
        NewVertex      = nv;
        Vertex         = v;
        @(posedge CLK);
        #1;
        StartPrimitive = 1'b0;
        EndPrimitive   = 1'b0;
        Draw           = 1'b0;
        NewVertex      = 1'b0;
    endtask

    task automatic vtx(input logic [31:0] v);
        cyc(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, v);
    endtask

    task automatic start(input logic [3:0] t);
        cyc(1'b1, t, 1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic idle();
        cyc(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic tri3(input string tag, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] c);
        check({tag, ".valid"}, 32'(out_valid), 32'd1);
        check({tag, ".v0"}, out_v0, a);
        check({tag, ".v1"}, out_v1, b);
        check({tag, ".v2"}, out_v2, c);
    endtask

    initial begin
        #1;
        check("rst.valid", 32'(out_valid), 32'd0);
        check("rst.stall", 32'(Stall), 32'd0);
        check("rst.count", 32'(prim_count), 32'd0);
        check("rst.err", 32'(err), 32'd0);
        @(negedge CLK);
        RESET = 1'b0;

        // Plain triangles
        start(4'd3);
        vtx(32'h00010002);
        vtx(32'h00030004);
        check("tri.early", 32'(out_valid), 32'd0);
        vtx(32'h00050006);
        tri3("tri", 32'h00010002, 32'h00030004, 32'h00050006);
        check("tri.type", 32'(out_type), 32'd3);
        check("tri.cmd", 32'(out_cmd), 32'd0);
        idle();
        check("tri.count", 32'(prim_count), 32'd1);
        check("tri.drop", 32'(out_valid), 32'd0);
        cyc(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, '0);

        // Triangle strip, winding alternates
        start(4'd4);
        vtx(32'h10);
        vtx(32'h11);
        vtx(32'h12);
        tri3("ts0", 32'h10, 32'h11, 32'h12);
        vtx(32'h13);
        tri3("ts1", 32'h12, 32'h11, 32'h13);
        check("ts1.count", 32'(prim_count), 32'd2);
        vtx(32'h14);
        tri3("ts2", 32'h12, 32'h13, 32'h14);
        idle();
        check("ts.count", 32'(prim_count), 32'd4);
        cyc(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, '0);

        // Line strip under back-pressure
        start(4'd2);
        vtx(32'h20);
        vtx(32'h21);
        check("ls0.v0", out_v0, 32'h20);
        check("ls0.v1", out_v1, 32'h21);
        check("ls0.type", 32'(out_type), 32'd1);
        out_ready = 1'b0;
        #1;
        check("bp.stall", 32'(Stall), 32'd1);
        vtx(32'h22);
        vtx(32'h22);
        check("bp.hold.v1", out_v1, 32'h21);
        check("bp.hold.cnt", 32'(prim_count), 32'd4);
        out_ready = 1'b1;
        vtx(32'h22);
        check("ls1.v0", out_v0, 32'h21);
        check("ls1.v1", out_v1, 32'h22);
        check("ls1.count", 32'(prim_count), 32'd5);
        idle();
        check("ls.once", 32'(out_valid), 32'd0);
        check("ls.count", 32'(prim_count), 32'd6);
        cyc(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, '0);

        // Partial triangle discarded, then Draw token
        start(4'd3);
        vtx(32'h30);
        vtx(32'h31);
        cyc(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, '0);
        check("disc.valid", 32'(out_valid), 32'd0);
        cyc(1'b0, 4'd0, 1'b0, 1'b1, 1'b0, '0);
        check("draw.valid", 32'(out_valid), 32'd1);
        check("draw.cmd", 32'(out_cmd), 32'd1);
        check("draw.type", 32'(out_type), 32'd0);
        check("draw.v0", out_v0, 32'd0);
        check("draw.v2", out_v2, 32'd0);
        idle();
        check("draw.count", 32'(prim_count), 32'd6);
        check("draw.err", 32'(err), 32'd0);

        // Error paths
        vtx(32'h40);
        check("idlev.err", 32'(err), 32'd1);
        check("idlev.valid", 32'(out_valid), 32'd0);
        start(4'd9);
        vtx(32'h41);
        check("bad.err", 32'(err), 32'd1);
        check("bad.valid", 32'(out_valid), 32'd0);

        // Counter wrap with 4-bit count
        @(negedge CLK);
        RESET = 1'b1;
        #1;
        check("rst2.err", 32'(err), 32'd0);
        @(negedge CLK);
        RESET = 1'b0;
        start(4'd0);
        for (int i = 0; i < 17; i++) vtx(32'h100 + 32'(i));
        check("pt.v0", out_v0, 32'h110);
        check("pt.type", 32'(out_type), 32'd0);
        idle();
        check("wrap.count", 32'(prim_count), 32'd1);
        cyc(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, '0);

        // Fan, then asynchronous reset mid-primitive
        start(4'd5);
        vtx(32'h50);
        vtx(32'h51);
        vtx(32'h52);
        tri3("fan0", 32'h50, 32'h51, 32'h52);
        vtx(32'h53);
        tri3("fan1", 32'h50, 32'h52, 32'h53);
        #2;
        RESET = 1'b1;
        #1;
        check("arst.valid", 32'(out_valid), 32'd0);
        check("arst.count", 32'(prim_count), 32'd0);
        check("arst.v0", out_v0, 32'd0);
        check("arst.stall", 32'(Stall), 32'd0);
        @(negedge CLK);
        RESET = 1'b0;
        vtx(32'h54);
        check("arst.idle", 32'(out_valid), 32'd0);
        check("arst.err", 32'(err), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
